// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between instruction fetch and the MEM
//   stage. Fixed data-over-fetch priority, one outstanding transaction at a
//   time, one-cycle grant and completion pulses.
//
//   Optional feature macro: MEM_ARB_STARVE_GUARD_EN
//     When defined, a starvation counter forces a fetch grant after
//     STARVE_LIMIT consecutive data grants issued while fetch was waiting.
//     When undefined, data priority is strict and no counter exists.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   if_req/if_addr                  fetch request and address
//   if_gnt/if_rvalid/if_rdata       fetch grant pulse, data-valid pulse, data
//   d_req/d_we/d_addr/d_wdata/d_wbe data request (d_we=1 store) and payload
//   d_gnt/d_rvalid/d_rdata          data grant pulse, completion pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wbe               registered memory request, held until ack
//   mem_ack/mem_rdata               memory acknowledge and read data
//   busy                            a transaction is in flight
//   owner                           1 = data owns the port, 0 = fetch
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  // fetch requester
  input  logic                      if_req,
  input  logic [ADDR_WIDTH-1:0]     if_addr,
  output logic                      if_gnt,
  output logic                      if_rvalid,
  output logic [DATA_WIDTH-1:0]     if_rdata,
  // data requester
  input  logic                      d_req,
  input  logic                      d_we,
  input  logic [ADDR_WIDTH-1:0]     d_addr,
  input  logic [DATA_WIDTH-1:0]     d_wdata,
  input  logic [DATA_WIDTH/8-1:0]   d_wbe,
  output logic                      d_gnt,
  output logic                      d_rvalid,
  output logic [DATA_WIDTH-1:0]     d_rdata,
  // memory side
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wbe,
  input  logic                      mem_ack,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  // status
  output logic                      busy,
  output logic                      owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t state;

  // High when fetch must win the arbitration ending this IDLE cycle.
  logic fetch_forced;

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("mem_port_arbiter: STARVE_LIMIT must be at least 1");
  end

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;

  assign fetch_forced = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Only arbitration edges (IDLE cycles) move the counter. Every outcome
  // other than "data granted while fetch waits" clears it: a fetch grant,
  // no fetch request, or an idle edge with no requests at all.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (if_req && d_req && !fetch_forced)
        starve_cnt <= starve_cnt + CNT_W'(1);
      else
        starve_cnt <= '0;
    end
  end
`else
  assign fetch_forced = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;
      d_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wbe   <= '0;
      owner     <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      d_gnt     <= 1'b0;
      d_rvalid  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (d_req && !fetch_forced) begin
            state     <= BUSY_D;
            d_gnt     <= 1'b1;
            owner     <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wbe   <= d_wbe;
          end else if (if_req) begin
            state     <= BUSY_IF;
            if_gnt    <= 1'b1;
            owner     <= 1'b0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_wbe   <= '0;
          end
        end

        BUSY_IF: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            if_rvalid <= 1'b1;
            if_rdata  <= mem_rdata;
          end
        end

        BUSY_D: begin
          if (mem_ack) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            d_rvalid <= 1'b1;
            // mem_we still holds the latched direction of this transaction.
            d_rdata  <= mem_we ? '0 : mem_rdata;
          end
        end

        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
